// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges pipeline GPR/HI-LO writeback with a single-entry
// auxiliary write buffer that yields to the pipeline and forces a stall when starved.
module wb_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        wb_whilo,
    input  logic        aux_req,
    input  logic [4:0]  aux_wd,
    input  logic [31:0] aux_wdata,
    output logic        aux_ack,
    output logic        aux_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt, cnt_inc;
    logic [4:0]  buf_wd;
    logic [31:0] buf_wdata;
    logic        capture;

    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (aux_req) begin
                    capture   = 1'b1;
                    state_nxt = PEND;
                    cnt_nxt   = '0;
                end
            end
            PEND, FORCE: begin
                // Grant when the pipeline is silent; drop when it overwrites the same register.
                if (!wb_wreg || (wb_wd == buf_wd)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (state == PEND) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == 4'(STARVE_MAX)) state_nxt = FORCE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            buf_wd    <= '0;
            buf_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                buf_wd    <= aux_wd;
                buf_wdata <= aux_wdata;
            end
        end
    end

    always_comb begin
        aux_ack   = 1'b0;
        aux_busy  = 1'b0;
        stall_req = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        hilo_we   = 1'b0;
        hi_o      = '0;
        lo_o      = '0;
        if (!rst) begin
            aux_ack   = capture;
            aux_busy  = (state != IDLE);
            stall_req = (state == FORCE);
            hilo_we   = wb_whilo;
            hi_o      = wb_hi;
            lo_o      = wb_lo;
            if (wb_wreg) begin
                rf_we    = 1'b1;
                rf_waddr = wb_wd;
                rf_wdata = wb_wdata;
            end else if (state != IDLE) begin
                rf_we    = 1'b1;
                rf_waddr = buf_wd;
                rf_wdata = buf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-cycle expected outputs queued with the
// stimulus and checked at the falling edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        aux_req;
    logic [4:0]  aux_wd;
    logic [31:0] aux_wdata;
    logic        aux_ack;
    logic        aux_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_req;

    wb_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .aux_req(aux_req), .aux_wd(aux_wd), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_busy(aux_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ack;
        logic        busy;
        logic        stall;
        logic        hwe;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic exp_t mk(logic we, logic [4:0] a, logic [31:0] d, logic ack,
                                logic busy, logic stall, logic hwe = 1'b0,
                                logic [31:0] hi = 32'h0, logic [31:0] lo = 32'h0);
        exp_t e;
        e.rf_we = we; e.waddr = a; e.wdata = d; e.ack = ack; e.busy = busy;
        e.stall = stall; e.hwe = hwe; e.hi = hi; e.lo = lo;
        return e;
    endfunction

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_wreg = we; wb_wd = a; wb_wdata = d;
    endtask

    task automatic aux(input logic req, input logic [4:0] a, input logic [31:0] d);
        aux_req = req; aux_wd = a; aux_wdata = d;
    endtask

    // Inputs for this cycle are already driven; queue the expectation, compare at negedge.
    task automatic cycle(input string tag, input exp_t e);
        exp_t  want;
        exp_t  got;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = mk(rf_we, rf_waddr, rf_wdata, aux_ack, aux_busy, stall_req, hilo_we, hi_o, lo_o);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", t, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset gates every output even with active inputs.
        rst = 1'b1;
        wb(1'b1, 5'd3, 32'hDEAD); wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        aux(1'b1, 5'd4, 32'h44);
        cycle("reset0", mk(0, 0, 0, 0, 0, 0));
        cycle("reset1", mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        wb(0, 0, 0); wb_whilo = 1'b0; wb_hi = 0; wb_lo = 0; aux(0, 0, 0);
        cycle("idle", mk(0, 0, 0, 0, 0, 0));

        // Capture then immediate grant.
        aux(1, 5'd5, 32'h1234);
        cycle("cap5_ack", mk(0, 0, 0, 1, 0, 0));
        aux(0, 0, 0);
        cycle("grant5", mk(1, 5'd5, 32'h1234, 0, 1, 0));
        cycle("idle_after5", mk(0, 0, 0, 0, 0, 0));

        // Capture concurrent with a pipeline write, then starve into FORCE; aux_req held.
        aux(1, 5'd7, 32'h77); wb(1, 5'd3, 32'h33);
        cycle("cap7_with_wb", mk(1, 5'd3, 32'h33, 1, 0, 0));
        for (int i = 1; i <= 4; i++)
            cycle($sformatf("block7_%0d", i), mk(1, 5'd3, 32'h33, 0, 1, 0));
        cycle("force7", mk(1, 5'd3, 32'h33, 0, 1, 1));
        cycle("force7_hold", mk(1, 5'd3, 32'h33, 0, 1, 1));
        wb(0, 0, 0);
        cycle("grant7_in_force", mk(1, 5'd7, 32'h77, 0, 1, 1));

        // Earliest new capture is the cycle after the grant.
        aux(1, 5'd9, 32'hAAAA);
        cycle("cap9_after_grant", mk(0, 0, 0, 1, 0, 0));
        aux(0, 0, 0); wb(1, 5'd9, 32'h5555);
        cycle("discard9", mk(1, 5'd9, 32'h5555, 0, 1, 0));
        wb(0, 0, 0);
        cycle("idle_after_discard", mk(0, 0, 0, 0, 0, 0));

        // HI/LO passthrough alongside a buffer grant.
        aux(1, 5'd12, 32'hC0C0);
        cycle("cap12", mk(0, 0, 0, 1, 0, 0));
        aux(0, 0, 0); wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        cycle("grant12_hilo", mk(1, 5'd12, 32'hC0C0, 0, 1, 0, 1, 32'h1, 32'h2));
        wb_whilo = 1'b0; wb_hi = 0; wb_lo = 0;

        // Register 0 is granted like any other.
        aux(1, 5'd0, 32'hFFFF);
        cycle("cap0", mk(0, 0, 0, 1, 0, 0));
        aux(0, 0, 0);
        cycle("grant0", mk(1, 5'd0, 32'hFFFF, 0, 1, 0));

        // Counter restarts per entry: three blocked cycles then grant must not stall.
        aux(1, 5'd10, 32'hA);
        cycle("cap10", mk(0, 0, 0, 1, 0, 0));
        aux(0, 0, 0); wb(1, 5'd3, 32'h33);
        for (int i = 1; i <= 3; i++)
            cycle($sformatf("block10_%0d", i), mk(1, 5'd3, 32'h33, 0, 1, 0));
        wb(0, 0, 0);
        cycle("grant10", mk(1, 5'd10, 32'hA, 0, 1, 0));

        // Reset while in FORCE drops the stall and the entry.
        aux(1, 5'd4, 32'h44);
        cycle("cap4", mk(0, 0, 0, 1, 0, 0));
        aux(0, 0, 0); wb(1, 5'd3, 32'h33);
        for (int i = 1; i <= 4; i++)
            cycle($sformatf("block4_%0d", i), mk(1, 5'd3, 32'h33, 0, 1, 0));
        cycle("force4", mk(1, 5'd3, 32'h33, 0, 1, 1));
        rst = 1'b1; wb(0, 0, 0);
        cycle("rst_in_force", mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        cycle("no_write4_a", mk(0, 0, 0, 0, 0, 0));
        cycle("no_write4_b", mk(0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
